// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_pkg.sv
// Shared constants for the ADC capture sequencer: state width and encodings.
package ad_ip_jesd204_tpl_adc_capture_ctrl_pkg;

    localparam int STATE_WIDTH = 2;

    // Encodings are visible on the debug state readback, so they are fixed.
    localparam logic [STATE_WIDTH-1:0] IDLE    = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ARMED   = 2'd1;
    localparam logic [STATE_WIDTH-1:0] CAPTURE = 2'd2;
    localparam logic [STATE_WIDTH-1:0] DONE    = 2'd3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = IDLE,
        ST_ARMED   = ARMED,
        ST_CAPTURE = CAPTURE,
        ST_DONE    = DONE
    } cap_state_e;

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Capture sequencer between the TPL ADC core and the DMA write port.
// Gates the sample stream into bounded captures of a programmed beat count,
// optionally waiting for a rising edge on an external trigger first.
//
// Handshake: there is no backpressure. A beat is transferred on every cycle
// link_valid is high; adc_valid_out marks, one cycle later, the beats that
// fell inside the capture window. dma_ovf is an after-the-fact indication
// that terminates the capture with the error flag set.
module ad_ip_jesd204_tpl_adc_capture_ctrl
    import ad_ip_jesd204_tpl_adc_capture_ctrl_pkg::*;
#(
    parameter int NUM_CHANNELS   = 1,
    parameter int DMA_DATA_WIDTH = 64,
    parameter int LENGTH_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [LENGTH_WIDTH-1:0]   cfg_length,
    input  logic                      cfg_sync_en,
    input  logic                      adc_sync_in,
    input  logic                      link_valid,
    input  logic [DMA_DATA_WIDTH-1:0] adc_data_in,
    input  logic                      dma_ovf,
    output logic [NUM_CHANNELS-1:0]   adc_valid_out,
    output logic [DMA_DATA_WIDTH-1:0] adc_data_out,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [LENGTH_WIDTH-1:0]   beat_count,
    output logic [STATE_WIDTH-1:0]    state
);

    cap_state_e                state_q, state_d;
    logic [LENGTH_WIDTH-1:0]   len_q, len_d;
    logic [LENGTH_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LENGTH_WIDTH-1:0]   cnt_inc;
    logic [NUM_CHANNELS-1:0]   valid_q, valid_d;
    logic [DMA_DATA_WIDTH-1:0] data_q, data_d;
    logic                      err_q, err_d;
    logic                      sync_dly_q;
    logic                      sync_rise;

    // Trigger edge: current level high, previous level low. The delay
    // register runs in every state so a level already high on arming
    // cannot fire the capture.
    assign sync_rise = adc_sync_in & ~sync_dly_q;

    // Beat counter increment that sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == {LENGTH_WIDTH{1'b1}}) ? cnt_q : cnt_q + LENGTH_WIDTH'(1);

    // Next-state and datapath decode; precedence abort > overflow > length > start.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        valid_d = '0;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                // cfg_sync_en only steers this transition, so it is not stored.
                if (start && !abort) begin
                    len_d = cfg_length;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (cfg_length == '0) begin
                        state_d = ST_DONE;
                    end else if (cfg_sync_en) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end

            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sync_rise) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dma_ovf) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (link_valid) begin
                    valid_d = '1;
                    data_d  = adc_data_in;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture registers and trigger delay, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
            sync_dly_q <= adc_sync_in;
        end
    end

    assign adc_valid_out = valid_q;
    assign adc_data_out  = data_q;
    assign busy          = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done          = (state_q == ST_DONE);
    assign error         = err_q;
    assign beat_count    = cnt_q;
    assign state         = state_q;

endmodule
